// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: stall requests, exception report and sequencing outputs between the pipeline and pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(parameter int PC_W = 32);
  logic            stallreq_if;
  logic            stallreq_id;
  logic            stallreq_exe;
  logic            stallreq_mem;
  logic            exc_valid;
  logic            exc_eret;
  logic [PC_W-1:0] cp0_epc;
  logic [3:0]      stall;
  logic [3:0]      bubble;
  logic            flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            busy;
  modport master (
    output stallreq_if, stallreq_id, stallreq_exe, stallreq_mem, exc_valid, exc_eret, cp0_epc,
    input  stall, bubble, flush, redirect_valid, redirect_pc, busy
  );
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_exe, stallreq_mem, exc_valid, exc_eret, cp0_epc,
    output stall, bubble, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble resolution, exception/ERET flush FSM and fetch redirect.
// Optional PIPE_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module pipe_hazard_ctrl #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst,
  pipe_hazard_ctrl_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [15:0]          perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, FLUSH} state_t;
  state_t          state, state_nxt;
  logic [PC_W-1:0] target, target_nxt, redirect_q;
  logic [3:0]      stall_c, bubble_c;
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state      <= IDLE;
      target     <= '0;
      redirect_q <= '0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      if (state_nxt == FLUSH && state != FLUSH) redirect_q <= target_nxt;
    end
  end
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    stall_c    = 4'b0000;
    bubble_c   = 4'b0000;
    if (state == IDLE) begin
      if (bus.exc_valid) begin
        target_nxt = bus.exc_eret ? bus.cp0_epc : EXC_VECTOR;
        state_nxt  = bus.stallreq_mem ? WAIT_MEM : FLUSH;
        stall_c    = 4'b1111;
        bubble_c   = 4'b1000;
      end else begin
        stall_c  = bus.stallreq_mem ? 4'b1111 : bus.stallreq_exe ? 4'b0111 :
                   bus.stallreq_id  ? 4'b0011 : bus.stallreq_if  ? 4'b0001 : 4'b0000;
        bubble_c = bus.stallreq_mem ? 4'b1000 : bus.stallreq_exe ? 4'b0100 :
                   bus.stallreq_id  ? 4'b0010 : bus.stallreq_if  ? 4'b0001 : 4'b0000;
      end
    end else if (state == WAIT_MEM) begin
      stall_c   = 4'b1111;
      bubble_c  = 4'b1000;
      state_nxt = bus.stallreq_mem ? WAIT_MEM : FLUSH;
    end else begin
      bubble_c  = 4'b1111;
      state_nxt = IDLE;
    end
  end
  assign bus.stall          = stall_c;
  assign bus.bubble         = bubble_c;
  assign bus.flush          = state == FLUSH;
  assign bus.redirect_valid = state == FLUSH;
  assign bus.redirect_pc    = redirect_q;
  assign bus.busy           = state != IDLE;
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (stall_c[0] && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (state == FLUSH && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst     = 1'b1;
  int   tests       = 0;
  int   fails       = 0;
  pipe_hazard_ctrl_if #(.PC_W(32)) bus ();
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_cnt;
`endif
  pipe_hazard_ctrl dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst(cpu_rst),
    .bus(bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 cpu_clk_50M = ~cpu_clk_50M;
  task automatic cyc();
    @(posedge cpu_clk_50M);
    #1;
  endtask
  task automatic set_in(input logic [3:0] req, input logic ev, input logic er, input logic [31:0] epc);
    {bus.stallreq_mem, bus.stallreq_exe, bus.stallreq_id, bus.stallreq_if} = req;
    bus.exc_valid = ev;
    bus.exc_eret  = er;
    bus.cp0_epc   = epc;
    #1;
  endtask
  task automatic test_reset();
    cpu_rst = 1'b1;
    set_in(4'b1111, 1'b1, 1'b1, 32'h1234_5678);
    cyc();
    cyc();
    tests++;
    if ({bus.flush, bus.redirect_valid, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctl got flush/rv/busy=%b want 000", {bus.flush, bus.redirect_valid, bus.busy});
    end
    tests++;
    if (bus.redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc got %h want 00000000", bus.redirect_pc);
    end
    cpu_rst = 1'b0;
    set_in(4'b0000, 1'b0, 1'b0, 32'h0);
    tests++;
    if ({bus.stall, bus.bubble} !== 8'b0000_0000) begin
      fails++;
      $display("FAIL reset_idle got stall/bubble=%b want 00000000", {bus.stall, bus.bubble});
    end
  endtask
  task automatic test_priority();
    logic [3:0] req [5] = '{4'b0101, 4'b0001, 4'b0010, 4'b1111, 4'b0000};
    logic [7:0] exp [5] = '{8'b0111_0100, 8'b0001_0001, 8'b0011_0010, 8'b1111_1000, 8'b0000_0000};
    for (int i = 0; i < 5; i++) begin
      set_in(req[i], 1'b0, 1'b0, 32'h0);
      tests++;
      if ({bus.stall, bus.bubble} !== exp[i]) begin
        fails++;
        $display("FAIL prio_%0d req=%b got stall/bubble=%b want %b", i, req[i], {bus.stall, bus.bubble}, exp[i]);
      end
      cyc();
    end
  endtask
  task automatic test_exception();
    set_in(4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF);
    tests++;
    if ({bus.stall, bus.bubble, bus.flush} !== 9'b1111_1000_0) begin
      fails++;
      $display("FAIL exc_n got stall/bubble/flush=%b want 111110000", {bus.stall, bus.bubble, bus.flush});
    end
    cyc();
    set_in(4'b1111, 1'b1, 1'b0, 32'h0);
    tests++;
    if ({bus.flush, bus.redirect_valid, bus.busy, bus.stall, bus.bubble} !== 11'b111_0000_1111) begin
      fails++;
      $display("FAIL exc_n1 got f/rv/busy/stall/bubble=%b want 11100001111", {bus.flush, bus.redirect_valid, bus.busy, bus.stall, bus.bubble});
    end
    tests++;
    if (bus.redirect_pc !== 32'hBFC0_0380) begin
      fails++;
      $display("FAIL exc_pc got %h want bfc00380", bus.redirect_pc);
    end
    cyc();
    set_in(4'b0000, 1'b0, 1'b0, 32'h0);
    tests++;
    if ({bus.flush, bus.redirect_valid, bus.busy, bus.stall, bus.bubble} !== 11'b000_0000_0000) begin
      fails++;
      $display("FAIL exc_n2 got f/rv/busy/stall/bubble=%b want 00000000000", {bus.flush, bus.redirect_valid, bus.busy, bus.stall, bus.bubble});
    end
    tests++;
    if (bus.redirect_pc !== 32'hBFC0_0380) begin
      fails++;
      $display("FAIL exc_pc_hold got %h want bfc00380", bus.redirect_pc);
    end
    cyc();
  endtask
  task automatic test_eret_wait();
    set_in(4'b1000, 1'b1, 1'b1, 32'h8000_1234);
    tests++;
    if ({bus.stall, bus.bubble, bus.flush} !== 9'b1111_1000_0) begin
      fails++;
      $display("FAIL eret_c1 got stall/bubble/flush=%b want 111110000", {bus.stall, bus.bubble, bus.flush});
    end
    for (int c = 2; c <= 4; c++) begin
      cyc();
      set_in({c < 4, 3'b000}, c < 4, 1'b1, 32'h0);
      tests++;
      if ({bus.busy, bus.stall, bus.bubble, bus.flush} !== 10'b1_1111_1000_0) begin
        fails++;
        $display("FAIL eret_c%0d got busy/stall/bubble/flush=%b want 1111110000", c, {bus.busy, bus.stall, bus.bubble, bus.flush});
      end
    end
    cyc();
    tests++;
    if ({bus.flush, bus.redirect_valid, bus.redirect_pc} !== {2'b11, 32'h8000_1234}) begin
      fails++;
      $display("FAIL eret_flush got f/rv=%b pc=%h want 11 80001234", {bus.flush, bus.redirect_valid}, bus.redirect_pc);
    end
    cyc();
    tests++;
    if ({bus.flush, bus.busy} !== 2'b00) begin
      fails++;
      $display("FAIL eret_after got flush/busy=%b want 00", {bus.flush, bus.busy});
    end
  endtask
  task automatic test_reset_mid_fsm();
    int seen = 0;
    set_in(4'b1000, 1'b1, 1'b0, 32'h0);
    cyc();
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_wait got busy=%b want 1", bus.busy);
    end
    cpu_rst = 1'b1;
    set_in(4'b0000, 1'b0, 1'b0, 32'h0);
    cyc();
    cpu_rst = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.flush, bus.stall} !== 6'b0) begin
      fails++;
      $display("FAIL rstmid_idle got busy/flush/stall=%b want 000000", {bus.busy, bus.flush, bus.stall});
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (bus.flush) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL rstmid_noflush got %0d flush pulses want 0", seen);
    end
  endtask
`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    cpu_rst = 1'b1;
    set_in(4'b0000, 1'b0, 1'b0, 32'h0);
    cyc();
    cpu_rst = 1'b0;
    set_in(4'b0001, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) cyc();
    for (int e = 0; e < 2; e++) begin
      set_in(4'b0000, 1'b1, 1'b0, 32'h0);
      cyc();
      set_in(4'b0000, 1'b0, 1'b0, 32'h0);
      cyc();
      cyc();
    end
    tests++;
    if (perf_stall_cycles !== 32'd7) begin
      fails++;
      $display("FAIL perf_stall got %0d want 7", perf_stall_cycles);
    end
    tests++;
    if (perf_flush_cnt !== 16'd2) begin
      fails++;
      $display("FAIL perf_flush got %0d want 2", perf_flush_cnt);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_priority();
    test_exception();
    test_eret_wait();
    test_reset_mid_fsm();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Resolves per-stage stall requests into a hold vector for PC/IF-ID/ID-EXE/EXE-MEM and a bubble vector for IF-ID/ID-EXE/EXE-MEM/MEM-WB.
- Runs the exception/ERET FSM that drives the global `flush` input of every pipeline register, including MEM/WB.
- Provides the fetch redirect target.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for any exception.
- PC_W, 32, width of PC/EPC buses.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on posedge.
- cpu_rst  in  1  synchronous, active-high reset.
- stallreq_if  in  1  inst SRAM not ready.
- stallreq_id  in  1  load-use hazard.
- stallreq_exe  in  1  multicycle divide busy.
- stallreq_mem  in  1  data SRAM/device access not complete.
- exc_valid  in  1  MEM stage reports exception (level, held while MEM stalled).
- exc_eret  in  1  qualifies exc_valid as ERET.
- cp0_epc  in  PC_W  current EPC.
- stall  out  4  hold enables {exemem, idexe, ifid, pc}, bit0 = pc.
- bubble  out  4  NOP-insert {memwb, exemem, idexe, ifid}, bit0 = ifid.
- flush  out  1  clear all pipeline registers.
- redirect_valid  out  1  fetch must load redirect_pc.
- redirect_pc  out  PC_W  redirect target.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (cpu_rst=1 at posedge):
  - state=IDLE; latched target=0.
  - flush=0, redirect_valid=0, redirect_pc=0, busy=0.
  - stall/bubble are combinational from state and inputs, so they are 0 when no requests are present.
  - Reset mid-FSM aborts to IDLE with no flush pulse.
- Stall resolution (combinational, state IDLE, no exception): highest stage wins.
  - mem: stall=1111, bubble=1000.
  - exe: stall=0111, bubble=0100.
  - id: stall=0011, bubble=0010.
  - if: stall=0001, bubble=0001.
  - none: 0000/0000.
- FSM states: IDLE, WAIT_MEM, FLUSH.
- IDLE:
  - exc_valid & !stallreq_mem: latch target (exc_eret ? cp0_epc : EXC_VECTOR) and go to FLUSH.
  - exc_valid & stallreq_mem: latch target and go to WAIT_MEM.
  - In the exc_valid cycle: stall=1111, bubble=1000, so the faulting instruction never commits to WB.
- WAIT_MEM:
  - stall=1111, bubble=1000, busy=1.
  - Leave to FLUSH on the first cycle with stallreq_mem=0.
  - exc_valid/cp0_epc are ignored; the latched target holds.
- FLUSH (exactly 1 cycle):
  - Registered outputs: flush=1, redirect_valid=1, redirect_pc=latched target, busy=1.
  - stall=0000, bubble=1111. Flush overrides every stall request in this cycle.
  - Next state is IDLE unconditionally; exc_valid in this cycle is ignored.
- Latency: exception seen in cycle N with no mem stall → flush and redirect pulse in cycle N+1 → new fetch in N+2.
- No back-to-back flushes. Minimum spacing between flush pulses is 2 cycles.
- redirect_pc holds its last value after the pulse; it is meaningful only while redirect_valid=1.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, the block adds outputs:
  - perf_stall_cycles (32): counts cycles with stall[0]=1.
  - perf_flush_cnt (16): counts FLUSH pulses.
- Both counters are synchronously cleared by cpu_rst and saturate at all-ones (no wrap).
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold cpu_rst=1 with all requests high for 2 cycles → flush=0, redirect_valid=0, busy=0. Release with all inputs 0 → stall=0000, bubble=0000.
- Priority: stallreq_if=1, stallreq_exe=1 → stall=0111, bubble=0100. Drop stallreq_exe → stall=0001, bubble=0001.
- Exception: exc_valid=1, exc_eret=0 in cycle N → cycle N: stall=1111, bubble=1000. Cycle N+1: flush=1, redirect_pc=32'hBFC00380, bubble=1111. Cycle N+2: IDLE, flush=0.
- ERET during mem wait: exc_valid=1, exc_eret=1, cp0_epc=32'h80001234, stallreq_mem=1 for 3 cycles (cp0_epc changes to 0 in cycle 2) → busy=1 and stall=1111 throughout. Flush/redirect with 32'h80001234 occurs exactly 1 cycle after stallreq_mem falls.
- Reset mid-FSM: assert cpu_rst while in WAIT_MEM → next cycle IDLE, no flush pulse ever issued for the aborted exception.
- PIPE_PERF_CNT_EN: 5 stalled cycles plus 2 exceptions → perf_stall_cycles=5 + exception freeze cycles (2), perf_flush_cnt=2. Preload near max → counters saturate at all-ones.
